// File: rtl/dma_channel_arbiter.sv
// Four-channel DMA request arbiter and hold-request handshake FSM.
// Define DMA_ARB_ROTATE_EN to enable rotating priority via the rotate input.
module dma_channel_arbiter #(
    parameter int NCH = 4
) (
    input  logic           clk,
    input  logic           Reset,
    input  logic [NCH-1:0] DREQ,
    input  logic [NCH-1:0] mask,
    input  logic           rotate,
    input  logic           block_mode,
    input  logic           HLDA,
    input  logic           xfer_done,
    input  logic           tc,
    input  logic           EOP_n,
    input  logic           clr_status,
    output logic           HRQ,
    output logic [NCH-1:0] DACK,
    output logic [1:0]     ch_select,
    output logic           xfer_start,
    output logic [NCH-1:0] tc_status
);
    localparam int CW = 2;
    localparam logic [NCH-1:0] ONE = {{(NCH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, REQ, GRANT, XFER, RELEASE} state_t;

    state_t         state_q, state_d;
    logic [1:0]     run_q;
    logic [CW-1:0]  ch_q, ch_d;
    logic           restart_q, restart_d;
    logic [NCH-1:0] tc_q, tc_d;
    logic [NCH-1:0] req;
    logic           win_vld;
    logic [CW-1:0]  win_idx, base;
    logic           tc_set, leave, grant_go;
    logic [CW-1:0]  leave_idx;

    assign req = DREQ & ~mask;

`ifdef DMA_ARB_ROTATE_EN
    // Index of the last channel to leave service; it becomes lowest priority.
    logic [CW-1:0] last_q;
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset)     last_q <= CW'(NCH - 1);
        else if (leave) last_q <= leave_idx;
    end
    assign base = rotate ? last_q + 1'b1 : '0;
`else
    logic unused_ptr;
    assign unused_ptr = ^{rotate, leave, leave_idx};
    assign base       = '0;
`endif

    // Scan from lowest to highest priority so the highest-priority hit lands last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[base + CW'(i)]) begin
                win_vld = 1'b1;
                win_idx = base + CW'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        restart_d = 1'b0;
        tc_set    = 1'b0;
        leave     = 1'b0;
        leave_idx = ch_q;
        grant_go  = 1'b0;
        case (state_q)
            IDLE:    if (run_q[1] && |req) state_d = REQ;
            REQ:     if (HLDA) state_d = GRANT;
            GRANT: begin
                if (!HLDA)         state_d = IDLE;
                else if (!win_vld) state_d = RELEASE;
                else if (!EOP_n) begin
                    state_d   = RELEASE;
                    ch_d      = win_idx;
                    tc_set    = 1'b1;
                    leave     = 1'b1;
                    leave_idx = win_idx;
                end else begin
                    state_d  = XFER;
                    ch_d     = win_idx;
                    grant_go = 1'b1;
                end
            end
            XFER: begin
                if (!HLDA) state_d = IDLE;
                else if (!EOP_n || (xfer_done && (tc || !block_mode))) begin
                    state_d = RELEASE;
                    leave   = 1'b1;
                    tc_set  = !EOP_n || tc;
                end else if (xfer_done) begin
                    restart_d = 1'b1;
                end
            end
            RELEASE: if (!HLDA) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A coincident set overrides clr_status for its own bit.
    always_comb begin
        tc_d = clr_status ? '0 : tc_q;
        if (tc_set) tc_d[leave_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            run_q     <= 2'b00;
            ch_q      <= '0;
            restart_q <= 1'b0;
            tc_q      <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= {run_q[0], 1'b1};
            ch_q      <= ch_d;
            restart_q <= restart_d;
            tc_q      <= tc_d;
        end
    end

    assign HRQ        = (state_q == REQ) || (state_q == GRANT) || (state_q == XFER);
    assign DACK       = grant_go ? (ONE << win_idx) :
                        (state_q == XFER) ? (ONE << ch_q) : '0;
    assign ch_select  = grant_go ? win_idx : ch_q;
    assign xfer_start = grant_go || (restart_q && state_q == XFER);
    assign tc_status  = tc_q;

endmodule

// File: doc/dma_channel_arbiter.md
DMA_CHANNEL_ARBITER -- requirements
Module: dma_channel_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 4, number of DMA channels; fixed at 4 in this release.
REQ-002 SHALL have port clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port DREQ  in  4  channel requests, active-high, level-sensitive.
REQ-005 SHALL have port mask  in  4  channel mask bits; 1 = channel ignored.
REQ-006 SHALL have port rotate  in  1  priority mode select: 0 = fixed, 1 = rotating.
REQ-007 SHALL have port block_mode  in  1  transfer mode: 1 = block, 0 = single.
REQ-008 SHALL have port HLDA  in  1  hold acknowledge from the processor.
REQ-009 SHALL have port xfer_done  in  1  one-cycle pulse from timing control marking the end of one transfer cycle.
REQ-010 SHALL have port tc  in  1  terminal count; valid only with xfer_done.
REQ-011 SHALL have port EOP_n  in  1  external end-of-process, active-low.
REQ-012 SHALL have port clr_status  in  1  one-cycle pulse that clears tc_status.
REQ-013 SHALL have port HRQ  out  1  hold request to the processor.
REQ-014 SHALL have port DACK  out  4  one-hot channel acknowledge.
REQ-015 SHALL have port ch_select  out  2  index of the granted channel.
REQ-016 SHALL have port xfer_start  out  1  one-cycle pulse that launches one transfer cycle.
REQ-017 SHALL have port tc_status  out  4  sticky per-channel terminal-count flags.

Function
REQ-018 SHALL use states IDLE, REQ, GRANT, XFER and RELEASE.
REQ-019 IDLE SHALL move to REQ on the cycle after any unmasked DREQ (DREQ & ~mask != 0) is seen; HRQ SHALL be 1 in REQ, GRANT and XFER.
REQ-020 REQ SHALL move to GRANT when HLDA = 1.
REQ-021 In GRANT the arbiter SHALL pick the winner from unmasked DREQ sampled that cycle.
REQ-022 If GRANT finds no unmasked request, the state SHALL go to RELEASE with no DACK.
REQ-023 With a winner, GRANT SHALL register ch_select, drive DACK one-hot, pulse xfer_start for 1 cycle and go to XFER.
REQ-024 Fixed priority SHALL be ch0 > ch1 > ch2 > ch3.
REQ-025 Rotating priority SHALL make the last-serviced channel the lowest priority; the pointer SHALL update only when a channel leaves service.
REQ-026 XFER SHALL hold DACK and ch_select stable until xfer_done.
REQ-027 On xfer_done with tc = 1, the state SHALL go to RELEASE and set tc_status[ch_select].
REQ-028 On xfer_done in single mode, the state SHALL go to RELEASE.
REQ-029 On xfer_done in block mode with tc = 0 and EOP_n = 1, the arbiter SHALL pulse xfer_start the next cycle and stay on the same channel, whatever DREQ does.
REQ-030 EOP_n = 0 sampled in GRANT or XFER SHALL go to RELEASE next cycle and set tc_status[ch_select]; any xfer_done in that cycle is ignored.
REQ-031 RELEASE SHALL drive HRQ = 0 and DACK = 0, and move to IDLE once HLDA = 0.
REQ-032 HLDA falling in GRANT or XFER SHALL force IDLE next cycle: HRQ = 0, DACK = 0, no tc_status update, priority pointer unchanged.
REQ-033 Masking the granted channel during XFER SHALL NOT abort the cycle in progress; it takes effect at the next GRANT.
REQ-034 clr_status SHALL clear tc_status; if it coincides with a set, the set SHALL win.
REQ-035 Latency SHALL be DREQ to HRQ 1 cycle, HLDA to DACK/xfer_start 1 cycle, and xfer_done to HRQ low 1 cycle.

Reset
REQ-036 While Reset = 0: state = IDLE, HRQ = 0, DACK = 0, ch_select = 0, xfer_start = 0, tc_status = 0, rotating pointer = ch0 highest; this SHALL apply immediately and asynchronously, including mid-transfer.
REQ-037 Reset release SHALL be synchronised to clk; the first arbitration SHALL occur no earlier than the second rising edge after Reset goes high.

Configuration
REQ-038 Macro DMA_ARB_ROTATE_EN defined SHALL enable rotating priority via the rotate input.
REQ-039 Macro DMA_ARB_ROTATE_EN undefined SHALL remove the pointer logic, ignore rotate and always use fixed priority.

Verification
REQ-040 Scenario: DREQ = 4'b1010, mask = 0, rotate = 0, HLDA 2 cycles after HRQ -> DACK = 4'b0010, ch_select = 1, one xfer_start pulse.
REQ-041 Scenario: rotate = 1 (macro defined), DREQ = 4'b1111 held, single mode, 4 services -> grant order ch0, ch1, ch2, ch3.
REQ-042 Scenario: block mode, ch2, xfer_done three times with tc = 1 on the third -> 3 xfer_start pulses, tc_status = 4'b0100, HRQ low 1 cycle later.
REQ-043 Scenario: EOP_n pulled low during XFER on ch3 -> RELEASE, DACK = 0, tc_status[3] = 1, IDLE after HLDA = 0.
REQ-044 Scenario: HLDA dropped in XFER -> IDLE next cycle, HRQ = 0, tc_status unchanged.
REQ-045 Scenario: Reset asserted in XFER with DACK = 4'b0001 -> all outputs 0 immediately, without waiting for a clock edge.
